// File: rtl/spike_pattern_sequencer.sv
// Spike pattern sequencer: plays stored per-channel spike trains into the
// network MSB first, drains for TAIL cycles with inputs low, counts output
// spikes per channel (saturating) and pulses done when a run completes.
//
// Ports
//   clk, rst_n  rising-edge clock, synchronous active-low reset
//   cfg_we      write pattern register cfg_sel with cfg_data (IDLE/DONE only)
//   cfg_sel     input channel index; values >= NUM_IN are ignored
//   cfg_data    pattern, bit PAT_LEN-1 played first
//   start       one-cycle pulse, begins a run from IDLE
//   abort       terminates a run in RUN/DRAIN without a done pulse
//   spk_in      registered spikes to the network, bit i = input channel i
//   spk_out     spikes from the network, bit j = output channel j
//   busy        high while in RUN or DRAIN
//   done        one-cycle pulse at normal run completion
//   cycle_idx   sample index of the current run cycle
//   spk_cnt     packed saturating counters, channel j at [j*CNT_W +: CNT_W]
module spike_pattern_sequencer #(
  parameter int unsigned PAT_LEN = 40,
  parameter int unsigned NUM_IN  = 3,
  parameter int unsigned NUM_OUT = 2,
  parameter int unsigned TAIL    = 4,
  parameter int unsigned CNT_W   = 6,
  parameter int unsigned IDX_W   = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [1:0]                 cfg_sel,
  input  logic [PAT_LEN-1:0]         cfg_data,
  input  logic                       start,
  input  logic                       abort,
  output logic [NUM_IN-1:0]          spk_in,
  input  logic [NUM_OUT-1:0]         spk_out,
  output logic                       busy,
  output logic                       done,
  output logic [IDX_W-1:0]           cycle_idx,
  output logic [NUM_OUT*CNT_W-1:0]   spk_cnt
);

  localparam int unsigned BIT_W = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IDX_W-1:0] LAST_RUN = IDX_W'(PAT_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_LEN + TAIL - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [IDX_W-1:0]   idx_nxt;
  logic [NUM_IN-1:0]  spk_in_nxt;
  logic [BIT_W-1:0]   bit_idx;
  logic               cnt_en;
  logic               cnt_clr;
  logic               cfg_ok;

  logic [PAT_LEN-1:0] pat [NUM_IN];

  // Pattern bit played in the cycle after the current RUN cycle
  assign bit_idx = BIT_W'(LAST_RUN - cycle_idx - IDX_W'(1));

  // Configuration is only accepted while no run is in flight
  assign cfg_ok = cfg_we && ((state == S_IDLE) || (state == S_DONE));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and next-output decode; abort outranks run/drain progress
  always_comb begin
    state_nxt  = state;
    idx_nxt    = cycle_idx;
    spk_in_nxt = '0;
    cnt_en     = 1'b0;
    cnt_clr    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
          idx_nxt   = '0;
          cnt_clr   = 1'b1;
          for (int i = 0; i < NUM_IN; i++) begin
            spk_in_nxt[i] = pat[i][PAT_LEN-1];
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_en = 1'b1;
          if (cycle_idx == LAST_RUN) begin
            if (TAIL == 0) begin
              state_nxt = S_DONE;
            end else begin
              state_nxt = S_DRAIN;
              idx_nxt   = cycle_idx + IDX_W'(1);
            end
          end else begin
            idx_nxt = cycle_idx + IDX_W'(1);
            for (int i = 0; i < NUM_IN; i++) begin
              spk_in_nxt[i] = pat[i][bit_idx];
            end
          end
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_en = 1'b1;
          if (cycle_idx == LAST_IDX) begin
            state_nxt = S_DONE;
          end else begin
            idx_nxt = cycle_idx + IDX_W'(1);
          end
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Registered outputs and run index
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spk_in    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cycle_idx <= '0;
    end else begin
      spk_in    <= spk_in_nxt;
      busy      <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
      done      <= (state_nxt == S_DONE);
      cycle_idx <= idx_nxt;
    end
  end

  // Pattern registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_IN; i++) begin
        pat[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (cfg_ok && (cfg_sel == 2'(i))) begin
          pat[i] <= cfg_data;
        end
      end
    end
  end

  // Saturating per-channel spike counters, cleared at run start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spk_cnt <= '0;
    end else if (cnt_clr) begin
      spk_cnt <= '0;
    end else if (cnt_en) begin
      for (int j = 0; j < NUM_OUT; j++) begin
        if (spk_out[j] && (spk_cnt[j*CNT_W +: CNT_W] != CNT_MAX)) begin
          spk_cnt[j*CNT_W +: CNT_W] <= spk_cnt[j*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end

endmodule
